// File: rtl/poly_compress.sv
// poly_compress: reduces invntt coefficient pairs mod 3329 and applies Kyber Compress_d
// through a three-stage ready/valid pipeline, pulsing done after 2^DEPTH coefficients drain.
module poly_compress #(
  parameter int DEPTH = 8,
  parameter int D = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             in_valid,
  input  logic [15:0]      din_1,
  input  logic [15:0]      din_2,
  input  logic [DEPTH-1:0] in_index,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*D-1:0]   dout,
  output logic [DEPTH-1:0] out_index,
  output logic             out_last,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [DEPTH-2:0] r_cnt;
  logic r_s1_v, r_s1_last, r_s2_v, r_s2_last;
  logic [15:0] r_s1_a, r_s1_b;
  logic [11:0] r_s2_a, r_s2_b;
  logic [DEPTH-1:0] r_s1_idx, r_s2_idx;
  logic w_stall, w_acc, w_full;

  // Adding 10q lifts every 16-bit value into [522, 66057]; 80636/2^28 is an exact quotient there
  function automatic logic [11:0] mod_q(input logic [15:0] x);
    logic [16:0] u;
    logic [5:0] q;
    u = {x[15], x} + 17'd33290;
    q = 6'((34'(u) * 34'd80636) >> 28);
    return 12'(u - 17'(q) * 17'd3329);
  endfunction

  // 10321340/2^35 divides by 3329 exactly for every numerator below 2^23
  function automatic logic [D-1:0] comp(input logic [11:0] r);
    return D'((((47'(r) << D) + 47'd1664) * 47'd10321340) >> 35);
  endfunction

  assign w_stall = out_valid & ~out_ready;
  assign w_acc = in_valid & in_ready;
  assign w_full = &r_cnt;

  always_comb begin
    w_next = r_state;
    in_ready = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE: w_next = RUN;
      RUN: begin
        in_ready = ~w_stall;
        if (in_valid && !w_stall && w_full) w_next = DRAIN;
      end
      DRAIN: if (out_valid && out_ready && out_last) w_next = DONE;
      DONE: begin
        done = 1'b1;
        w_next = IDLE;
      end
    endcase
    if (!set) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (!set || r_state == IDLE) ? '0 : w_acc ? r_cnt + (DEPTH-1)'(1) : r_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_s1_v, r_s1_last, r_s2_v, r_s2_last, out_valid, out_last} <= '0;
      r_s1_a <= '0;
      r_s1_b <= '0;
      r_s1_idx <= '0;
      r_s2_a <= '0;
      r_s2_b <= '0;
      r_s2_idx <= '0;
      dout <= '0;
      out_index <= '0;
    end else if (!set) begin
      {r_s1_v, r_s1_last, r_s2_v, r_s2_last, out_valid, out_last} <= '0;
    end else if (!w_stall) begin
      r_s1_v <= w_acc;
      r_s1_last <= w_acc & w_full;
      r_s1_a <= din_1;
      r_s1_b <= din_2;
      r_s1_idx <= in_index;
      r_s2_v <= r_s1_v;
      r_s2_last <= r_s1_last;
      r_s2_a <= mod_q(r_s1_a);
      r_s2_b <= mod_q(r_s1_b);
      r_s2_idx <= r_s1_idx;
      out_valid <= r_s2_v;
      out_last <= r_s2_last;
      dout <= {comp(r_s2_a), comp(r_s2_b)};
      out_index <= r_s2_idx;
    end
  end
endmodule

// File: tb/tb_poly_compress.sv
// tb_poly_compress: randomized streams through D=4 and D=10 instances, checked against
// an integer-arithmetic model of mod-q reduction and Compress_d.
module tb_poly_compress;
  typedef struct packed {logic last; logic [7:0] idx; logic [19:0] d10; logic [7:0] d4;} rec_t;
  logic clk = 0, reset = 0, set = 0, in_valid = 0, out_ready = 1;
  logic signed [15:0] din_1 = 0, din_2 = 0;
  logic [7:0] in_index = 0;
  logic in_ready, out_valid, out_last, done, in_ready10, out_valid10, out_last10, done10;
  logic [7:0] dout, out_index, out_index10;
  logic [19:0] dout10;
  int tests = 0, fails = 0, hold_err = 0, ctl_err = 0, done_cnt = 0;
  bit prev_stall = 0;
  logic [37:0] prev_snap = '0;
  rec_t got_q[$], exp_q[$];
  logic signed [15:0] a_arr[128], b_arr[128];
  logic [7:0] idx_arr[128];

  always #5 clk = ~clk;

  poly_compress #(.DEPTH(8), .D(4)) dut (
    .clk(clk), .reset(reset), .set(set), .in_valid(in_valid), .din_1(din_1), .din_2(din_2),
    .in_index(in_index), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_index(out_index), .out_last(out_last), .done(done));

  poly_compress #(.DEPTH(8), .D(10)) dut10 (
    .clk(clk), .reset(reset), .set(set), .in_valid(in_valid), .din_1(din_1), .din_2(din_2),
    .in_index(in_index), .in_ready(in_ready10), .out_valid(out_valid10), .out_ready(out_ready),
    .dout(dout10), .out_index(out_index10), .out_last(out_last10), .done(done10));

  function automatic int comp_ref(input int x, input int d);
    int r;
    r = x % 3329;
    if (r < 0) r += 3329;
    return ((r << d) + 1664) / 3329 % (1 << d);
  endfunction

  function automatic rec_t model(input int a, input int b, input logic [7:0] idx, input logic last);
    rec_t e;
    e.last = last;
    e.idx = idx;
    e.d10 = {10'(comp_ref(a, 10)), 10'(comp_ref(b, 10))};
    e.d4 = {4'(comp_ref(a, 4)), 4'(comp_ref(b, 4))};
    return e;
  endfunction

  // Handshakes are decided by values that are stable from this negedge to the next posedge
  always @(negedge clk) begin
    if (!reset) prev_stall = 0;
    else begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_index, dout10, dout});
      if (prev_stall && {out_valid, out_last, out_index, dout, dout10} !== prev_snap) hold_err++;
      if ({in_ready10, out_valid10, out_index10, out_last10, done10} !== {in_ready, out_valid, out_index, out_last, done}) ctl_err++;
      prev_stall = out_valid && !out_ready && set;
      prev_snap = {out_valid, out_last, out_index, dout, dout10};
      if (done) done_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic abort;
    set = 0; in_valid = 0; out_ready = 1;
    idle(2);
  endtask

  task automatic fill_random;
    for (int k = 0; k < 128; k++) begin
      a_arr[k] = 16'($urandom);
      b_arr[k] = 16'($urandom);
      idx_arr[k] = 8'($urandom) & 8'hFE;
    end
    a_arr[0] = -32768; b_arr[0] = 32767;
    a_arr[1] = 3329;   b_arr[1] = -3329;
    a_arr[2] = 1664;   b_arr[2] = 1665;
    a_arr[3] = 0;      b_arr[3] = -1;
  endtask

  task automatic start_poly(output bit tmo);
    set = 1;
    tmo = 1;
    for (int i = 0; i < 10 && tmo; i++) begin
      @(negedge clk);
      tmo = !in_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_stream(input int n, input bit rnd, input bit wait_done,
                            output int stall_cyc, output int ir_bad, output int done_gap, output bit tmo);
    int k, guard, last_at;
    k = 0; guard = 0; last_at = -1;
    stall_cyc = 0; ir_bad = 0; done_gap = -1; tmo = 0;
    while (k < n && guard < 4 * n + 100) begin
      in_valid = 1; din_1 = a_arr[k]; din_2 = b_arr[k]; in_index = idx_arr[k];
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a_arr[k], b_arr[k], idx_arr[k], k == 127));
        k++;
      end else stall_cyc++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 0;
    tmo = (k < n);
    if (wait_done) begin
      tmo = 1;
      for (int c = 1; c <= 300; c++) begin
        @(negedge clk);
        if (done) begin
          done_gap = (last_at > 0) ? c - last_at : -1;
          tmo = 0;
          break;
        end
        if (in_ready) ir_bad++;
        if (out_valid && out_ready && out_last) last_at = c;
        @(posedge clk); #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
  endtask

  task automatic test_reset;
    reset = 0;
    idle(2);
    tests++;
    if ({in_ready, out_valid, dout, out_index, out_last, done} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state got %b %b %h %h %b %b exp all zero", in_ready, out_valid, dout, out_index, out_last, done);
    end
    reset = 1;
    idle(1);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_idle_ready got %b exp 0", in_ready); end
  endtask

  task automatic test_latency;
    rec_t e;
    got_q.delete();
    abort();
    set = 1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL lat_ready_same_cycle got %b exp 0", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_ready_next_cycle got %b exp 1", in_ready); end
    in_valid = 1; din_1 = 1664; din_2 = 0; in_index = 8'h2A;
    e = model(1664, 0, 8'h2A, 1'b0);
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_too_early got %b exp 0", out_valid); end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || dout !== 8'h80) begin
      fails++; $display("FAIL lat_output got valid=%b dout=%h exp valid=1 dout=80", out_valid, dout);
    end
    tests++;
    if ({out_last, out_index, dout10, dout} !== e) begin
      fails++; $display("FAIL lat_record got %h exp %h", {out_last, out_index, dout10, dout}, e);
    end
    abort();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_abort_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_vectors;
    logic [7:0] want[3];
    int st, irb, gap;
    bit t1, t2;
    want[0] = 8'h00; want[1] = 8'h04; want[2] = 8'hD2;
    a_arr[0] = -1;    b_arr[0] = 3328;
    a_arr[1] = -3328; b_arr[1] = 832;
    a_arr[2] = 32767; b_arr[2] = 417;
    for (int k = 0; k < 3; k++) idx_arr[k] = 8'(2 * k + 10);
    got_q.delete(); exp_q.delete();
    start_poly(t1);
    run_stream(3, 0, 0, st, irb, gap, t2);
    idle(5);
    tests++;
    if (t1 || t2 || got_q.size() != 3) begin fails++; $display("FAIL vec_count got %0d exp 3 (timeout %b%b)", got_q.size(), t1, t2); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= got_q.size() || got_q[i].d4 !== want[i] || got_q[i].idx !== idx_arr[i]) begin
        fails++;
        $display("FAIL vec[%0d] got %h exp dout=%h idx=%h", i, (i < got_q.size()) ? got_q[i] : rec_t'(0), want[i], idx_arr[i]);
      end
    end
    abort();
  endtask

  task automatic test_d10;
    int st, irb, gap;
    bit t1, t2;
    a_arr[0] = -1000; b_arr[0] = 1000; idx_arr[0] = 8'hFE;
    got_q.delete(); exp_q.delete();
    start_poly(t1);
    run_stream(1, 0, 0, st, irb, gap, t2);
    idle(5);
    tests++;
    if (t1 || t2 || got_q.size() != 1 || got_q[0].d10 !== {10'd716, 10'd308}) begin
      fails++;
      $display("FAIL d10_value got %h exp %h", (got_q.size() > 0) ? got_q[0].d10 : 20'h0, {10'd716, 10'd308});
    end
    tests++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      fails++; $display("FAIL d10_record got %h exp %h", (got_q.size() > 0) ? got_q[0] : rec_t'(0), exp_q[0]);
    end
    abort();
  endtask

  task automatic test_full_stream;
    int st, irb, gap, d0;
    bit t1, t2;
    rec_t g;
    fill_random();
    got_q.delete(); exp_q.delete();
    d0 = done_cnt;
    start_poly(t1);
    run_stream(128, 0, 1, st, irb, gap, t2);
    tests++;
    if (t1 || t2) begin fails++; $display("FAIL full_timeout got %b%b exp 00", t1, t2); end
    tests++;
    if (st != 0) begin fails++; $display("FAIL full_throughput got %0d stall cycles exp 0", st); end
    tests++;
    if (got_q.size() != 128) begin fails++; $display("FAIL full_count got %0d exp 128", got_q.size()); end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL full[%0d] got %h exp %h", i, g, exp_q[i]); end
    end
    tests++;
    if (irb != 0) begin fails++; $display("FAIL full_ready_after_last got %0d high cycles exp 0", irb); end
    tests++;
    if (gap != 1) begin fails++; $display("FAIL full_done_gap got %0d exp 1", gap); end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL full_done_pulses got %0d exp 1", done_cnt - d0); end
    abort();
  endtask

  task automatic test_random_ready;
    int st, irb, gap, d0;
    bit t1, t2;
    rec_t g;
    got_q.delete(); exp_q.delete();
    hold_err = 0;
    d0 = done_cnt;
    start_poly(t1);
    run_stream(128, 1, 1, st, irb, gap, t2);
    tests++;
    if (t1 || t2 || got_q.size() != 128) begin
      fails++; $display("FAIL rnd_count got %0d exp 128 (timeout %b%b)", got_q.size(), t1, t2);
    end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL rnd[%0d] got %h exp %h", i, g, exp_q[i]); end
    end
    tests++;
    if (hold_err != 0) begin fails++; $display("FAIL rnd_hold got %0d unstable stalls exp 0", hold_err); end
    tests++;
    if (gap != 1 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL rnd_done got gap=%0d pulses=%0d exp gap=1 pulses=1", gap, done_cnt - d0);
    end
    tests++;
    if (ctl_err != 0) begin fails++; $display("FAIL ctl_match got %0d diverging cycles exp 0", ctl_err); end
    abort();
  endtask

  task automatic test_abort;
    int st, irb, gap, d0, g0;
    bit t1, t2;
    rec_t g;
    fill_random();
    got_q.delete(); exp_q.delete();
    start_poly(t1);
    run_stream(40, 0, 0, st, irb, gap, t2);
    set = 0;
    @(posedge clk); #1;
    g0 = got_q.size();
    d0 = done_cnt;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b exp 0", out_valid); end
    tests++;
    if (t1 || t2 || g0 != 38) begin fails++; $display("FAIL abort_delivered got %0d exp 38", g0); end
    idle(10);
    tests++;
    if (got_q.size() != g0 || done_cnt != d0) begin
      fails++; $display("FAIL abort_quiet got outputs=%0d done=%0d exp outputs=%0d done=%0d", got_q.size(), done_cnt, g0, d0);
    end
    start_poly(t1);
    run_stream(5, 0, 0, st, irb, gap, t2);
    reset = 0;
    #1;
    tests++;
    if ({in_ready, out_valid, dout, out_index, out_last, done} !== 19'd0) begin
      fails++;
      $display("FAIL abort_reset_state got %b %b %h %h %b %b exp all zero", in_ready, out_valid, dout, out_index, out_last, done);
    end
    set = 0;
    idle(2);
    reset = 1;
    idle(2);
    tests++;
    if (done_cnt != d0) begin fails++; $display("FAIL abort_no_done got %0d exp %0d", done_cnt, d0); end
    got_q.delete(); exp_q.delete();
    start_poly(t1);
    run_stream(128, 0, 1, st, irb, gap, t2);
    tests++;
    if (t1 || t2 || got_q.size() != 128) begin
      fails++; $display("FAIL fresh_count got %0d exp 128 (timeout %b%b)", got_q.size(), t1, t2);
    end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : '0;
      tests++;
      if (g !== exp_q[i]) begin fails++; $display("FAIL fresh[%0d] got %h exp %h", i, g, exp_q[i]); end
    end
    tests++;
    if (gap != 1 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL fresh_done got gap=%0d pulses=%0d exp gap=1 pulses=1", gap, done_cnt - d0);
    end
    abort();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_d10();
    test_full_stream();
    test_random_ready();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
